fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output-side reorder buffer for the streaming float FFT pipeline. Consumes the stage-chain output stream: one complex single-precision sample per valid cycle, frames of 2^bram_addr_len samples in bit-reversed index order. Uses a ping-pong pair of inferred block RAMs to re-emit each frame in natural index order as a gap-free burst. It is the reader for the radix stage stream and sits after the last radix stage.

## Interface
Parameters:
- float_len, 32: width of one float component; a complex sample is {real, imag}, 2*float_len bits, real in the upper half.
- bram_addr_len, 13: log2 of the frame length N (8192 by default). Valid range is 2..13.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  2*float_len  sample from the last radix stage.
- data_in_valid  input  1  data_in is valid this cycle. Gaps between valid cycles are allowed.
- data_out  output  2*float_len  reordered sample, registered.
- data_out_valid  output  1  data_out is valid. Registered.
- data_out_last  output  1  marks the sample with natural index N-1 of a frame. Registered.

## Operation
- Frame definition: N consecutive accepted samples (data_in_valid=1) form one frame. The first sample after reset is frame sample 0.
- Write side:
  - wr_cnt counts 0..N-1 and wr_bank is 0 or 1.
  - An accepted sample is written to bank wr_bank at address wr_cnt.
  - When wr_cnt=N-1: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Read side FSM, states IDLE and READ; rd_cnt counts 0..N-1 and rd_bank is 0 or 1.
  - IDLE -> READ when full[rd_bank]=1. rd_cnt starts at 0.
  - In READ, one read per cycle from bank rd_bank at address bitrev(rd_cnt), where bitrev reverses the bram_addr_len bits.
  - At rd_cnt=N-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt. If full of the new rd_bank is already 1 (including a set in this same cycle), stay in READ with no bubble; otherwise go to IDLE.
- Result: output sample n of a frame equals input sample bitrev(n) of that frame.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other bank in the same cycle are independent; both take effect.
  - A write and a read hit different banks, so there is no RAM conflict.
- Overflow cannot occur. Input rate is at most 1 per cycle and readout takes exactly N cycles, so a bank is always drained before it is refilled. The bench asserts that a write never targets a bank with full=1.
- Data is passed bit-exact: no arithmetic, no width change.

## Timing
- Reset values: data_out=0, data_out_valid=0, data_out_last=0, wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full=2'b00, FSM=IDLE. RAM contents are not reset.
- Reset mid-operation: the partial frame being written and any frame being read are discarded. The first output after reset is 0 at the clock edge where rst is sampled high. The next accepted sample after reset is sample 0 of a new frame.
- Read pipeline:
  - Cycle T: the frame's N-th sample is accepted.
  - T+1: the FSM enters READ and issues address bitrev(0).
  - T+2: RAM data is available.
  - T+3: data_out is registered with data_out_valid=1.
  - Latency from the last input accept to the first output is 3 cycles.
- A burst is exactly N consecutive valid cycles. data_out_last=1 only on the N-th.
- Back-to-back input frames (valid held high) give continuous output, with data_out_valid held high across frame boundaries.
- When data_out_valid=0, data_out=0.

## Test plan
- bram_addr_len=3, one frame with real part = index 0..7 and imag = 0, valid held high:
  - output real parts are 0,4,2,6,1,5,3,7;
  - the first valid appears 3 cycles after the 8th input;
  - data_out_last is set on value 7 only.
- Same frame with data_in_valid toggled 1,0,1,0,…: the output is identical, still a gap-free 8-cycle burst starting 3 cycles after the last accept.
- Three back-to-back frames with valid held high (values 0..23): data_out_valid stays high for 24 cycles and the outputs are 0,4,2,6,1,5,3,7, then 8,12,10,14,9,13,11,15, then 16,20,…,23.
- Reset asserted after 5 samples, then a full frame of values 100..107: the first 5 samples never appear, and the output is 100,104,102,106,101,105,103,107.
- Reset asserted during a burst at output sample 3: all outputs are 0 on the next edge. After rst is released, no output appears until a fresh 8-sample frame is written.
- bram_addr_len=13, random 64-bit data, two frames: each output n matches input bitrev13(n) bit-exact, and the no-overflow assertion never fires.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order frame reorder buffer with ping-pong RAM banks.
// Latency: 3 cycles from the last accepted sample of a frame to its first output.
// No backpressure: accepts one sample per cycle and emits each frame as a gap-free N-cycle burst.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   data_in        complex sample {real, imag} in bit-reversed frame order
//   data_in_valid  data_in is accepted this cycle
//   data_out       reordered sample, zero when not valid (registered)
//   data_out_valid data_out is valid (registered)
//   data_out_last  marks natural index N-1 of a frame (registered)
module fft_bitrev_reorder #(
  parameter int float_len     = 32,
  parameter int bram_addr_len = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  output logic [2*float_len-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   data_out_last
);

  localparam int W = 2 * float_len;
  localparam int N = 1 << bram_addr_len;
  localparam logic [bram_addr_len-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, READ} state_t;

  logic [W-1:0] mem0 [N];
  logic [W-1:0] mem1 [N];

  logic [bram_addr_len-1:0] wr_cnt;
  logic [bram_addr_len-1:0] rd_cnt;
  logic [bram_addr_len-1:0] rd_addr;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [1:0]               full;
  logic [1:0]               full_nx;
  state_t                   state;
  logic                     wr_done;
  logic                     rd_done;

  // RAM output stage and its sideband, aligned with the registered RAM read
  logic [W-1:0] q0;
  logic [W-1:0] q1;
  logic         q_sel;
  logic         q_vld;
  logic         q_last;

  function automatic logic [bram_addr_len-1:0] bitrev(input logic [bram_addr_len-1:0] a);
    logic [bram_addr_len-1:0] r;
    for (int i = 0; i < bram_addr_len; i++) begin
      r[i] = a[bram_addr_len-1-i];
    end
    return r;
  endfunction

  assign wr_done = data_in_valid && (wr_cnt == CNT_MAX);
  assign rd_done = (state == READ) && (rd_cnt == CNT_MAX);
  assign rd_addr = bitrev(rd_cnt);

  // Next full flags. The FSM looks at these rather than the registered flags so
  // that a frame completing this cycle starts readout on the very next cycle,
  // both from IDLE and at the end of a burst (no bubble between frames).
  // Set and clear always target different banks, since the writer never fills
  // a bank that is still being drained.
  always_comb begin
    full_nx = full;
    if (wr_done) full_nx[wr_bank] = 1'b1;
    if (rd_done) full_nx[rd_bank] = 1'b0;
  end

  // Bank RAMs: one write port, one registered read port each, no reset.
  always_ff @(posedge clk) begin
    if (!rst && data_in_valid && !wr_bank) mem0[wr_cnt] <= data_in;
    q0 <= mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst && data_in_valid && wr_bank) mem1[wr_cnt] <= data_in;
    q1 <= mem1[rd_addr];
  end

  // Write counter, full flags, read FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt         <= '0;
      wr_bank        <= 1'b0;
      rd_cnt         <= '0;
      rd_bank        <= 1'b0;
      full           <= 2'b00;
      state          <= IDLE;
      q_sel          <= 1'b0;
      q_vld          <= 1'b0;
      q_last         <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end else begin
      full <= full_nx;

      // Counter width equals the address width, so N-1 wraps to 0 naturally.
      if (data_in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end

      case (state)
        IDLE: begin
          if (full_nx[rd_bank]) begin
            state  <= READ;
            rd_cnt <= '0;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_done) begin
            rd_bank <= ~rd_bank;
            if (!full_nx[~rd_bank]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Sideband tracks the address issued this cycle into the RAM read stage.
      q_sel  <= rd_bank;
      q_vld  <= (state == READ);
      q_last <= rd_done;

      data_out_valid <= q_vld;
      data_out_last  <= q_last;
      data_out       <= q_vld ? (q_sel ? q1 : q0) : '0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: a small-frame (N=8) and a full-size
// (N=8192) instance driven by directed and random frames; a frame-level model
// predicts every output word, its last flag and the exact cycle it must appear.
module tb_fft_bitrev_reorder;

  localparam int NS = 8;
  localparam int NL = 8192;

  typedef struct {
    logic [63:0] dat;
    logic        last;
    int          edge_n;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] din_s, din_l;
  logic        vld_s, vld_l;
  logic [63:0] dout_s, dout_l;
  logic        ov_s, ov_l;
  logic        ol_s, ol_l;

  int cyc;
  int n_cmp;
  int n_err;
  logic done;

  exp_t        exp_s[$];
  exp_t        exp_l[$];
  logic [63:0] frm_s[$];
  logic [63:0] frm_l[$];
  int          end_s, end_l;

  fft_bitrev_reorder #(.float_len(32), .bram_addr_len(3)) dut_s (
    .clk(clk), .rst(rst), .data_in(din_s), .data_in_valid(vld_s),
    .data_out(dout_s), .data_out_valid(ov_s), .data_out_last(ol_s)
  );

  fft_bitrev_reorder #(.float_len(32), .bram_addr_len(13)) dut_l (
    .clk(clk), .rst(rst), .data_in(din_l), .data_in_valid(vld_l),
    .data_out(dout_l), .data_out_valid(ov_l), .data_out_last(ol_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int brev(input int x, input int bits);
    int r = 0;
    int v = x;
    for (int k = 0; k < bits; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference model: collect accepted samples into frames; a completed frame
  // yields N outputs in natural order, starting 2 edges after its last accept
  // or right after the previous burst, whichever is later.
  always @(posedge clk) begin
    int e;
    int st;
    exp_t x;
    e = cyc;
    if (rst) begin
      frm_s.delete(); exp_s.delete(); end_s = -1000;
      frm_l.delete(); exp_l.delete(); end_l = -1000;
    end else begin
      if (vld_s) begin
        frm_s.push_back(din_s);
        if (frm_s.size() == NS) begin
          st = imax(e + 2, end_s + 1);
          for (int n = 0; n < NS; n++) begin
            x.dat = frm_s[brev(n, 3)]; x.last = (n == NS - 1); x.edge_n = st + n;
            exp_s.push_back(x);
          end
          end_s = st + NS - 1;
          frm_s.delete();
        end
      end
      if (vld_l) begin
        frm_l.push_back(din_l);
        if (frm_l.size() == NL) begin
          st = imax(e + 2, end_l + 1);
          for (int n = 0; n < NL; n++) begin
            x.dat = frm_l[brev(n, 13)]; x.last = (n == NL - 1); x.edge_n = st + n;
            exp_l.push_back(x);
          end
          end_l = st + NL - 1;
          frm_l.delete();
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: all checking happens here, half a cycle away from the active edge.
  always @(negedge clk) begin
    int lbl;
    exp_t x;
    lbl = cyc - 1;

    if (ov_s) begin
      if (exp_s.size() == 0) cmp("s_spurious_valid", 64'd1, 64'd0);
      else begin
        x = exp_s.pop_front();
        cmp("s_data", dout_s, x.dat);
        cmp("s_last", {63'd0, ol_s}, {63'd0, x.last});
        cmp("s_cycle", 64'(lbl), 64'(x.edge_n));
      end
    end else begin
      cmp("s_idle_data", dout_s, 64'd0);
      cmp("s_idle_last", {63'd0, ol_s}, 64'd0);
    end

    if (ov_l) begin
      if (exp_l.size() == 0) cmp("l_spurious_valid", 64'd1, 64'd0);
      else begin
        x = exp_l.pop_front();
        cmp("l_data", dout_l, x.dat);
        cmp("l_last", {63'd0, ol_l}, {63'd0, x.last});
        cmp("l_cycle", 64'(lbl), 64'(x.edge_n));
      end
    end else begin
      cmp("l_idle_data", dout_l, 64'd0);
      cmp("l_idle_last", {63'd0, ol_l}, 64'd0);
    end

    // A write must never land in a bank still waiting to be drained.
    if (!rst && vld_s) cmp("s_overflow", {63'd0, dut_s.full[dut_s.wr_bank]}, 64'd0);
    if (!rst && vld_l) cmp("l_overflow", {63'd0, dut_l.full[dut_l.wr_bank]}, 64'd0);

    if (done) begin
      cmp("s_pending_outputs", 64'(exp_s.size()), 64'd0);
      cmp("l_pending_outputs", 64'(exp_l.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic drv_s(input logic v, input logic [63:0] d);
    vld_s = v; din_s = d;
    @(posedge clk); #1;
  endtask

  task automatic drv_l(input logic v, input logic [63:0] d);
    vld_l = v; din_l = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    vld_s = 1'b0; vld_l = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [63:0] re(input int v);
    return {32'(v), 32'd0};
  endfunction

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0; done = 1'b0;
    end_s = -1000; end_l = -1000;
    rst = 1'b1; vld_s = 1'b0; vld_l = 1'b0; din_s = '0; din_l = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Single frame, valid held high.
    for (int i = 0; i < NS; i++) drv_s(1'b1, re(i));
    idle(14);

    // Same frame with alternating valid; gap cycles carry junk data.
    for (int i = 0; i < NS; i++) begin
      drv_s(1'b1, re(i));
      drv_s(1'b0, {$urandom, $urandom});
    end
    idle(14);

    // Three back-to-back frames.
    for (int i = 0; i < 3 * NS; i++) drv_s(1'b1, re(i));
    idle(14);

    // Partial frame discarded by reset, then a clean frame.
    for (int i = 0; i < 5; i++) drv_s(1'b1, re(50 + i));
    rst = 1'b1;
    drv_s(1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) drv_s(1'b1, re(100 + i));
    idle(14);

    // Reset landing on output sample 3 of a burst; nothing may follow.
    for (int i = 0; i < NS; i++) drv_s(1'b1, re(200 + i));
    idle(4);
    rst = 1'b1;
    drv_s(1'b0, '0);
    rst = 1'b0;
    idle(20);
    for (int i = 0; i < NS; i++) drv_s(1'b1, {$urandom, $urandom});
    idle(14);

    // Random data with random input gaps.
    for (int i = 0; i < 4 * NS; i++) begin
      if ($urandom_range(0, 2) == 0) drv_s(1'b0, {$urandom, $urandom});
      drv_s(1'b1, {$urandom, $urandom});
    end
    idle(14);

    // Full-size frames of random data, valid held high.
    for (int i = 0; i < 2 * NL; i++) drv_l(1'b1, {$urandom, $urandom});
    idle(NL + 20);

    done = 1'b1;
  end

endmodule
